multi_cycle_cpu: RTL and testbench

MULTI_CYCLE_CPU -- requirements
Module: multi_cycle_cpu

---
 rtl/multi_cycle_cpu_pkg.sv | 81 ++++++++
 rtl/mcpu_regfile.sv | 31 +++
 rtl/multi_cycle_cpu.sv | 275 +++++++++++++++++++++++++++
 tb/tb_multi_cycle_cpu.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_cycle_cpu_pkg.sv
// Shared definitions for the multi-cycle CPU: opcodes, funct codes,
// FSM state encoding, ALU operation codes and small decode helpers.
package multi_cycle_cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ERET  = 6'b010000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_ERET = 6'b011000;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;

    typedef enum logic [2:0] {
        S_IF        = 3'd0,
        S_ID        = 3'd1,
        S_EX        = 3'd2,
        S_MEM_RD    = 3'd3,
        S_MEM_WR    = 3'd4,
        S_WB        = 3'd5,
        S_INT_ENTRY = 3'd6
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOR = 4'd5,
        ALU_SLT = 4'd6,
        ALU_SLL = 4'd7,
        ALU_SRL = 4'd8,
        ALU_LUI = 4'd9
    } alu_op_e;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic [31:0] zext16(input logic [15:0] imm);
        return {16'h0000, imm};
    endfunction

    // True for every opcode/funct pair the core executes; anything else is a NOP.
    function automatic logic insn_defined(input logic [5:0] op, input logic [5:0] fn);
        logic ok;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR,
                    F_SLT, F_SLL, F_SRL, F_JR: ok = 1'b1;
                    default:                   ok = 1'b0;
                endcase
            end
            OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
            OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: ok = 1'b1;
            OP_ERET: ok = (fn == F_ERET);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mcpu_regfile.sv
// 32 x 32-bit register file: two asynchronous read ports, one synchronous
// write port. Register $0 is hard-wired to zero.
module mcpu_regfile (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i
);

    logic [31:0] regs_q [32];

    // Clear all registers on reset; otherwise commit a write unless it targets $0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (we_i && (wa_i != 5'd0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : regs_q[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : regs_q[ra2_i];

endmodule

// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-subset CPU on a single unified memory/IO bus.
// Control FSM, ALU and datapath registers; the register file is a sub-module.
// Bus outputs are registered from the next-state values so they are glitch-free.
module multi_cycle_cpu
    import multi_cycle_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] INT_VECTOR   = 32'h0000_0004,
    parameter int          HAS_INT      = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Data_in,
    input  logic        MIO_ready,
    input  logic        INT,
    output logic [31:0] Addr_out,
    output logic [31:0] Data_out,
    output logic        mem_w,
    output logic        CPU_MIO,
    output logic [31:0] PC_out,
    output logic [2:0]  state
);

    state_e      state_q, state_d, nxt_s;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d;
    logic [31:0] a_q, a_d, b_q, b_d, alu_out_q, alu_out_d, epc_q, epc_d;
    logic        ie_q, ie_d;
    logic [31:0] addr_q, addr_d;
    logic        cpu_mio_q, cpu_mio_d, mem_w_q, mem_w_d;

    logic        fetch_req_s, int_take_s;
    logic        rf_we_s;
    logic [4:0]  rf_wa_s;
    logic [31:0] rf_wd_s, rs_data_s, rt_data_s;
    alu_op_e     alu_op_s;
    logic [31:0] alu_b_s, alu_res_s;

    logic [5:0]  opcode_s, funct_s;
    logic [4:0]  rs_s, rt_s, rd_s, shamt_s;
    logic [15:0] imm_s;
    logic [31:0] jump_tgt_s;

    assign opcode_s   = ir_q[31:26];
    assign rs_s       = ir_q[25:21];
    assign rt_s       = ir_q[20:16];
    assign rd_s       = ir_q[15:11];
    assign shamt_s    = ir_q[10:6];
    assign funct_s    = ir_q[5:0];
    assign imm_s      = ir_q[15:0];
    assign jump_tgt_s = {pc_q[31:28], ir_q[25:0], 2'b00};

    mcpu_regfile u_regfile (
        .clk_i  (clk),
        .rst_ni (reset),
        .ra1_i  (rs_s),
        .ra2_i  (rt_s),
        .rd1_o  (rs_data_s),
        .rd2_o  (rt_data_s),
        .we_i   (rf_we_s),
        .wa_i   (rf_wa_s),
        .wd_i   (rf_wd_s)
    );

    function automatic logic [31:0] alu_compute(input alu_op_e op, input logic [31:0] a,
                                                input logic [31:0] b, input logic [4:0] sh);
        logic [31:0] r;
        case (op)
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_NOR: r = ~(a | b);
            ALU_SLT: r = {31'd0, ($signed(a) < $signed(b))};
            ALU_SLL: r = b << sh;
            ALU_SRL: r = b >> sh;
            ALU_LUI: r = {b[15:0], 16'h0000};
            default: r = a + b;
        endcase
        return r;
    endfunction

    // ALU control: choose operation and second operand from the latched instruction.
    always_comb begin
        alu_op_s = ALU_ADD;
        alu_b_s  = sext16(imm_s);
        case (opcode_s)
            OP_RTYPE: begin
                alu_b_s = b_q;
                case (funct_s)
                    F_ADD:   alu_op_s = ALU_ADD;
                    F_SUB:   alu_op_s = ALU_SUB;
                    F_AND:   alu_op_s = ALU_AND;
                    F_OR:    alu_op_s = ALU_OR;
                    F_XOR:   alu_op_s = ALU_XOR;
                    F_NOR:   alu_op_s = ALU_NOR;
                    F_SLT:   alu_op_s = ALU_SLT;
                    F_SLL:   alu_op_s = ALU_SLL;
                    F_SRL:   alu_op_s = ALU_SRL;
                    default: alu_op_s = ALU_ADD;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: alu_op_s = ALU_ADD;
            OP_SLTI: alu_op_s = ALU_SLT;
            OP_ANDI: begin alu_op_s = ALU_AND; alu_b_s = zext16(imm_s); end
            OP_ORI:  begin alu_op_s = ALU_OR;  alu_b_s = zext16(imm_s); end
            OP_LUI:  begin alu_op_s = ALU_LUI; alu_b_s = zext16(imm_s); end
            default: begin alu_op_s = ALU_ADD; alu_b_s = sext16(imm_s); end
        endcase
        alu_res_s = alu_compute(alu_op_s, a_q, alu_b_s, shamt_s);
    end

    // Next-state and datapath control; fetch_req_s marks every return towards IF,
    // which is the only point where a pending interrupt may divert the FSM.
    always_comb begin
        nxt_s       = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        mdr_d       = mdr_q;
        a_d         = a_q;
        b_d         = b_q;
        alu_out_d   = alu_out_q;
        epc_d       = epc_q;
        ie_d        = ie_q;
        fetch_req_s = 1'b0;
        rf_we_s     = 1'b0;
        rf_wa_s     = 5'd0;
        rf_wd_s     = alu_out_q;
        case (state_q)
            S_IF: begin
                if (MIO_ready) begin
                    ir_d  = Data_in;
                    pc_d  = pc_q + 32'd4;
                    nxt_s = S_ID;
                end else begin
                    nxt_s = S_IF;
                end
            end
            S_ID: begin
                a_d       = rs_data_s;
                b_d       = rt_data_s;
                alu_out_d = pc_q + (sext16(imm_s) << 2);
                if (!insn_defined(opcode_s, funct_s)) begin
                    fetch_req_s = 1'b1;
                end else if (opcode_s == OP_J) begin
                    pc_d        = jump_tgt_s;
                    fetch_req_s = 1'b1;
                end else if (opcode_s == OP_JAL) begin
                    pc_d        = jump_tgt_s;
                    rf_we_s     = 1'b1;
                    rf_wa_s     = 5'd31;
                    rf_wd_s     = pc_q;
                    fetch_req_s = 1'b1;
                end else begin
                    nxt_s = S_EX;
                end
            end
            S_EX: begin
                case (opcode_s)
                    OP_BEQ: begin
                        if (a_q == b_q) pc_d = alu_out_q;
                        else            pc_d = pc_q;
                        fetch_req_s = 1'b1;
                    end
                    OP_BNE: begin
                        if (a_q != b_q) pc_d = alu_out_q;
                        else            pc_d = pc_q;
                        fetch_req_s = 1'b1;
                    end
                    OP_ERET: begin
                        pc_d        = epc_q;
                        ie_d        = 1'b1;
                        fetch_req_s = 1'b1;
                    end
                    OP_LW: begin
                        alu_out_d = alu_res_s;
                        nxt_s     = S_MEM_RD;
                    end
                    OP_SW: begin
                        alu_out_d = alu_res_s;
                        nxt_s     = S_MEM_WR;
                    end
                    OP_RTYPE: begin
                        if (funct_s == F_JR) begin
                            pc_d        = a_q;
                            fetch_req_s = 1'b1;
                        end else begin
                            alu_out_d = alu_res_s;
                            nxt_s     = S_WB;
                        end
                    end
                    default: begin
                        alu_out_d = alu_res_s;
                        nxt_s     = S_WB;
                    end
                endcase
            end
            S_MEM_RD: begin
                if (MIO_ready) begin
                    mdr_d = Data_in;
                    nxt_s = S_WB;
                end else begin
                    nxt_s = S_MEM_RD;
                end
            end
            S_MEM_WR: begin
                if (MIO_ready) fetch_req_s = 1'b1;
                else           nxt_s = S_MEM_WR;
            end
            S_WB: begin
                rf_we_s     = 1'b1;
                rf_wa_s     = (opcode_s == OP_RTYPE) ? rd_s : rt_s;
                rf_wd_s     = (opcode_s == OP_LW) ? mdr_q : alu_out_q;
                fetch_req_s = 1'b1;
            end
            S_INT_ENTRY: begin
                epc_d = pc_q;
                pc_d  = INT_VECTOR;
                ie_d  = 1'b0;
                nxt_s = S_IF;
            end
            default: nxt_s = S_IF;
        endcase

        int_take_s = (HAS_INT != 0) && INT && ie_d;
        if (fetch_req_s) begin
            state_d = int_take_s ? S_INT_ENTRY : S_IF;
        end else begin
            state_d = nxt_s;
        end

        cpu_mio_d = (state_d == S_IF) || (state_d == S_MEM_RD) || (state_d == S_MEM_WR);
        mem_w_d   = (state_d == S_MEM_WR);
        addr_d    = (state_d == S_IF) ? pc_d : alu_out_d;
    end

    // State, datapath and bus-output registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IF;
            pc_q      <= RESET_VECTOR;
            ir_q      <= 32'd0;
            mdr_q     <= 32'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            alu_out_q <= 32'd0;
            epc_q     <= 32'd0;
            ie_q      <= 1'b1;
            addr_q    <= RESET_VECTOR;
            cpu_mio_q <= 1'b1;
            mem_w_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mdr_q     <= mdr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
            epc_q     <= epc_d;
            ie_q      <= ie_d;
            addr_q    <= addr_d;
            cpu_mio_q <= cpu_mio_d;
            mem_w_q   <= mem_w_d;
        end
    end

    assign Addr_out = addr_q;
    assign Data_out = b_q;
    assign mem_w    = mem_w_q;
    assign CPU_MIO  = cpu_mio_q;
    assign PC_out   = pc_q;
    assign state    = state_q;

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Directed testbench for multi_cycle_cpu: small programs in a bench memory,
// hand-computed expected register/PC/bus values checked at falling edges.
module tb_multi_cycle_cpu;
    import multi_cycle_cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MIO_ready = 1'b1;
    logic        INT = 1'b0;
    logic [31:0] Data_in, Addr_out, Data_out, PC_out;
    logic        mem_w, CPU_MIO;
    logic [2:0]  state;

    logic [31:0] mem [0:255];
    int          checks = 0;
    int          passed = 0;
    int          wr_cnt = 0;
    logic [31:0] wr_addr = 32'd0;
    logic [31:0] wr_data = 32'd0;

    always #5 clk = ~clk;

    assign Data_in = mem[Addr_out[9:2]];

    multi_cycle_cpu dut (
        .clk       (clk),
        .reset     (reset),
        .Data_in   (Data_in),
        .MIO_ready (MIO_ready),
        .INT       (INT),
        .Addr_out  (Addr_out),
        .Data_out  (Data_out),
        .mem_w     (mem_w),
        .CPU_MIO   (CPU_MIO),
        .PC_out    (PC_out),
        .state     (state)
    );

    // Record every acknowledged bus write.
    always @(posedge clk) begin
        if (reset && CPU_MIO && mem_w && MIO_ready) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= Addr_out;
            wr_data <= Data_out;
        end
    end

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    endtask

    task automatic start_prog();
        reset = 1'b0;
        MIO_ready = 1'b1;
        INT = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        checks++; if (state !== 3'd0) $display("FAIL reset_state got %0d want 0", state); else passed++;
        checks++; if (PC_out !== 32'h0) $display("FAIL reset_pc got %h want 00000000", PC_out); else passed++;
        checks++; if (CPU_MIO !== 1'b1) $display("FAIL reset_cpu_mio got %b want 1", CPU_MIO); else passed++;
        checks++; if (mem_w !== 1'b0) $display("FAIL reset_mem_w got %b want 0", mem_w); else passed++;
        checks++; if (Addr_out !== 32'h0) $display("FAIL reset_addr got %h want 00000000", Addr_out); else passed++;
        checks++; if (dut.ie_q !== 1'b1) $display("FAIL reset_ie got %b want 1", dut.ie_q); else passed++;
        checks++; if (dut.epc_q !== 32'h0) $display("FAIL reset_epc got %h want 0", dut.epc_q); else passed++;
        checks++; if (dut.u_regfile.regs_q[31] !== 32'h0) $display("FAIL reset_r31 got %h want 0", dut.u_regfile.regs_q[31]); else passed++;
    endtask

    task automatic test_add();
        clear_mem();
        mem[0] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5);
        mem[1] = enc_i(OP_ADDI, 5'd0, 5'd2, 16'd7);
        mem[2] = enc_r(5'd1, 5'd2, 5'd3, 5'd0, F_ADD);
        mem[3] = enc_j(OP_J, 26'd3);
        start_prog();
        repeat (8) @(negedge clk);
        checks++; if (PC_out !== 32'h8) $display("FAIL add_pc_before got %h want 00000008", PC_out); else passed++;
        checks++; if (dut.u_regfile.regs_q[2] !== 32'd7) $display("FAIL add_r2 got %h want 7", dut.u_regfile.regs_q[2]); else passed++;
        repeat (3) @(negedge clk);
        checks++; if (dut.u_regfile.regs_q[3] !== 32'd0) $display("FAIL add_r3_early got %h want 0", dut.u_regfile.regs_q[3]); else passed++;
        checks++; if (state !== 3'd5) $display("FAIL add_state_wb got %0d want 5", state); else passed++;
        @(negedge clk);
        checks++; if (dut.u_regfile.regs_q[3] !== 32'd12) $display("FAIL add_r3 got %h want 0000000c", dut.u_regfile.regs_q[3]); else passed++;
        checks++; if (PC_out !== 32'hC) $display("FAIL add_pc got %h want 0000000c", PC_out); else passed++;
    endtask

    task automatic test_alu();
        logic [4:0]  idx [17];
        logic [31:0] exp [17];
        clear_mem();
        mem[0]  = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5);
        mem[1]  = enc_i(OP_ADDI, 5'd0, 5'd2, 16'hFFFD);
        mem[2]  = enc_r(5'd1, 5'd2, 5'd3, 5'd0, F_SUB);
        mem[3]  = enc_r(5'd1, 5'd2, 5'd4, 5'd0, F_AND);
        mem[4]  = enc_r(5'd1, 5'd2, 5'd5, 5'd0, F_OR);
        mem[5]  = enc_r(5'd1, 5'd2, 5'd6, 5'd0, F_XOR);
        mem[6]  = enc_r(5'd1, 5'd2, 5'd7, 5'd0, F_NOR);
        mem[7]  = enc_r(5'd2, 5'd1, 5'd8, 5'd0, F_SLT);
        mem[8]  = enc_r(5'd0, 5'd1, 5'd9, 5'd4, F_SLL);
        mem[9]  = enc_r(5'd0, 5'd2, 5'd10, 5'd28, F_SRL);
        mem[10] = enc_i(OP_SLTI, 5'd2, 5'd11, 16'hFFFE);
        mem[11] = enc_i(OP_ANDI, 5'd2, 5'd12, 16'hFFF0);
        mem[12] = enc_i(OP_ORI, 5'd1, 5'd13, 16'h8000);
        mem[13] = enc_i(OP_LUI, 5'd0, 5'd14, 16'h1234);
        mem[14] = enc_i(OP_ADDI, 5'd0, 5'd0, 16'd1);
        mem[15] = enc_r(5'd0, 5'd0, 5'd15, 5'd0, F_ADD);
        mem[16] = enc_j(OP_JAL, 26'h20);
        mem[32] = enc_i(6'b111111, 5'd1, 5'd3, 16'h0001);
        mem[33] = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'b111111);
        mem[34] = enc_j(OP_J, 26'h22);
        idx = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd31, 5'd0};
        exp = '{32'd5, 32'hFFFF_FFFD, 32'd8, 32'd5, 32'hFFFF_FFFD, 32'hFFFF_FFF8, 32'd2,
                32'd1, 32'h50, 32'hF, 32'd1, 32'h0000_FFF0, 32'h8005, 32'h1234_0000,
                32'd0, 32'h44, 32'd0};
        start_prog();
        repeat (66) @(negedge clk);
        checks++; if (PC_out !== 32'h80) $display("FAIL jal_pc got %h want 00000080", PC_out); else passed++;
        repeat (4) @(negedge clk);
        checks++; if (PC_out !== 32'h88) $display("FAIL nop_pc got %h want 00000088", PC_out); else passed++;
        for (int i = 0; i < 17; i++) begin
            checks++;
            if (dut.u_regfile.regs_q[idx[i]] !== exp[i])
                $display("FAIL alu_reg r%0d got %h want %h", idx[i], dut.u_regfile.regs_q[idx[i]], exp[i]);
            else passed++;
        end
        repeat (2) @(negedge clk);
        checks++; if (PC_out !== 32'h88 || state !== 3'd0) $display("FAIL jloop pc %h state %0d want 00000088 0", PC_out, state); else passed++;
    endtask

    task automatic test_lw();
        clear_mem();
        mem[0] = enc_i(OP_LW, 5'd0, 5'd4, 16'd8);
        mem[1] = enc_j(OP_J, 26'd1);
        mem[2] = 32'hDEAD_BEEF;
        start_prog();
        repeat (3) @(negedge clk);
        MIO_ready = 1'b0;
        checks++; if (state !== 3'd3 || Addr_out !== 32'd8) $display("FAIL lw_memrd state %0d addr %h want 3 00000008", state, Addr_out); else passed++;
        checks++; if (CPU_MIO !== 1'b1 || mem_w !== 1'b0) $display("FAIL lw_bus mio %b w %b want 1 0", CPU_MIO, mem_w); else passed++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (state !== 3'd3 || Addr_out !== 32'd8) $display("FAIL lw_wait%0d state %0d addr %h want 3 00000008", i, state, Addr_out);
            else passed++;
        end
        MIO_ready = 1'b1;
        @(negedge clk);
        checks++; if (state !== 3'd5 || dut.u_regfile.regs_q[4] !== 32'd0) $display("FAIL lw_wb state %0d r4 %h want 5 0", state, dut.u_regfile.regs_q[4]); else passed++;
        @(negedge clk);
        checks++; if (dut.u_regfile.regs_q[4] !== 32'hDEAD_BEEF) $display("FAIL lw_r4 got %h want deadbeef", dut.u_regfile.regs_q[4]); else passed++;
        checks++; if (PC_out !== 32'h4) $display("FAIL lw_pc got %h want 00000004", PC_out); else passed++;
    endtask

    task automatic test_branch();
        clear_mem();
        mem[0] = enc_j(OP_J, 26'd4);
        mem[4] = enc_i(OP_BEQ, 5'd1, 5'd1, 16'hFFFF);
        start_prog();
        repeat (3) @(negedge clk);
        checks++; if (PC_out !== 32'h14) $display("FAIL beq_fetch_pc got %h want 00000014", PC_out); else passed++;
        repeat (2) @(negedge clk);
        checks++; if (PC_out !== 32'h10 || state !== 3'd0) $display("FAIL beq_taken pc %h state %0d want 00000010 0", PC_out, state); else passed++;
        clear_mem();
        mem[0]  = enc_j(OP_J, 26'd4);
        mem[4]  = enc_i(OP_BNE, 5'd1, 5'd1, 16'hFFFF);
        mem[5]  = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd1);
        mem[6]  = enc_i(OP_BNE, 5'd1, 5'd0, 16'd3);
        mem[10] = enc_j(OP_J, 26'd10);
        start_prog();
        repeat (5) @(negedge clk);
        checks++; if (PC_out !== 32'h14) $display("FAIL bne_not_taken pc %h want 00000014", PC_out); else passed++;
        repeat (7) @(negedge clk);
        checks++; if (PC_out !== 32'h28) $display("FAIL bne_taken pc %h want 00000028", PC_out); else passed++;
    endtask

    task automatic test_interrupt();
        int base;
        clear_mem();
        mem[0] = enc_j(OP_J, 26'd4);
        mem[1] = {OP_ERET, 20'd0, F_ERET};
        mem[4] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'h0055);
        mem[5] = enc_j(OP_J, 26'd8);
        mem[8] = enc_i(OP_SW, 5'd0, 5'd1, 16'h0100);
        mem[9] = enc_j(OP_J, 26'd9);
        base = wr_cnt;
        start_prog();
        repeat (10) @(negedge clk);
        checks++; if (state !== 3'd2) $display("FAIL int_sw_ex state %0d want 2", state); else passed++;
        INT = 1'b1;
        @(negedge clk);
        checks++; if (state !== 3'd4 || mem_w !== 1'b1) $display("FAIL int_memwr state %0d w %b want 4 1", state, mem_w); else passed++;
        checks++; if (Addr_out !== 32'h100 || Data_out !== 32'h55) $display("FAIL int_sw_bus addr %h data %h want 00000100 00000055", Addr_out, Data_out); else passed++;
        @(negedge clk);
        checks++; if (state !== 3'd6) $display("FAIL int_entry state %0d want 6", state); else passed++;
        checks++; if (wr_cnt !== base + 1 || wr_data !== 32'h55) $display("FAIL int_store cnt %0d data %h want %0d 00000055", wr_cnt, wr_data, base + 1); else passed++;
        @(negedge clk);
        checks++; if (PC_out !== 32'h4 || dut.epc_q !== 32'h24) $display("FAIL int_vec pc %h epc %h want 00000004 00000024", PC_out, dut.epc_q); else passed++;
        checks++; if (dut.ie_q !== 1'b0 || state !== 3'd0) $display("FAIL int_ie ie %b state %0d want 0 0", dut.ie_q, state); else passed++;
        repeat (3) @(negedge clk);
        checks++; if (PC_out !== 32'h24 || dut.ie_q !== 1'b1) $display("FAIL eret pc %h ie %b want 00000024 1", PC_out, dut.ie_q); else passed++;
        checks++; if (state !== 3'd6) $display("FAIL eret_pending state %0d want 6", state); else passed++;
        INT = 1'b0;
        @(negedge clk);
        checks++; if (PC_out !== 32'h4 || dut.epc_q !== 32'h24) $display("FAIL reentry pc %h epc %h want 00000004 00000024", PC_out, dut.epc_q); else passed++;
    endtask

    task automatic test_reset_mid_write();
        int base;
        clear_mem();
        mem[0] = enc_i(OP_SW, 5'd0, 5'd0, 16'h0100);
        start_prog();
        repeat (3) @(negedge clk);
        MIO_ready = 1'b0;
        checks++; if (state !== 3'd4 || mem_w !== 1'b1) $display("FAIL rst_pre_memwr state %0d w %b want 4 1", state, mem_w); else passed++;
        base = wr_cnt;
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++; if (state !== 3'd0 || PC_out !== 32'h0) $display("FAIL rst_async state %0d pc %h want 0 00000000", state, PC_out); else passed++;
        checks++; if (mem_w !== 1'b0 || CPU_MIO !== 1'b1 || Addr_out !== 32'h0) $display("FAIL rst_async_bus w %b mio %b addr %h want 0 1 0", mem_w, CPU_MIO, Addr_out); else passed++;
        MIO_ready = 1'b1;
        @(negedge clk);
        checks++; if (wr_cnt !== base || state !== 3'd0) $display("FAIL rst_hold cnt %0d state %0d want %0d 0", wr_cnt, state, base); else passed++;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (state !== 3'd1 || PC_out !== 32'h4) $display("FAIL first_fetch state %0d pc %h want 1 00000004", state, PC_out); else passed++;
    endtask

    initial begin
        clear_mem();
        #1;
        test_reset();
        test_add();
        test_alu();
        test_lw();
        test_branch();
        test_interrupt();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
